ifu_fetch: RTL and testbench

- Instruction fetch stage of the single-issue NPC core; sits directly upstream of the decode stage.
- Owns the program counter and issues one word read per instruction on the instruction-memory request/response interface.
- Delivers each fetched instruction and its PC to decode over a valid/ready handshake.
- Accepts a PC redirect (branch/jump target) from execute and discards in-flight or held instructions.

---
 rtl/npc_pkg.sv | 14 +
 rtl/ifu_pc_reg.sv | 37 +++
 rtl/ifu_fetch.sv | 114 +++++++++++
 tb/tb_ifu_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: reset value, sequential +4 advance and aligned redirect.
module ifu_pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Redirect beats advance; redirect targets are forced word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & ~ADDR_W'(3);
    end else if (advance_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, result held for decode.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_count
);

  fetch_state_t      state_q, state_d;
  logic              discard_q, discard_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       count_q, count_d;
  logic              advance;
  logic [ADDR_W-1:0] pc;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .advance_i        (advance),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_o             (pc)
  );

  // Next-state logic; a redirect always reloads pc inside ifu_pc_reg.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    count_d   = count_q;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid) state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          // Accepted request targets the old pc: its response must be dropped.
          if (redirect_valid) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          discard_d = 1'b0;
          if (redirect_valid || discard_q) begin
            state_d = REQ;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc;
            state_d   = HOLD;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          count_d = count_q + 32'd1;
          advance = 1'b1;
          state_d = REQ;
        end else if (redirect_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, discard flag and decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      inst_q    <= INST_NOP;
      inst_pc_q <= RESET_PC;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      count_q   <= count_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign inst_valid     = (state_q == HOLD);
  assign imem_req_addr  = pc;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch.
module tb_ifu_fetch;

  localparam logic [31:0] IA  = 32'h0010_0093;
  localparam logic [31:0] IB  = 32'h0020_0113;
  localparam logic [31:0] IC  = 32'h0030_0193;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int NV = 36;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rq;    // imem_req_ready
    logic        rv;    // imem_resp_valid
    logic [31:0] rd;    // imem_resp_data
    logic        ir;    // inst_ready
    logic        dv;    // redirect_valid
    logic [31:0] dpc;   // redirect_pc
    logic        ereq;  // expected after the edge
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] einst;
    logic [31:0] eipc;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [NV];

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rq, logic rv, logic [31:0] rd, logic ir, logic dv,
                              logic [31:0] dpc, logic ereq, logic [31:0] eaddr, logic eiv,
                              logic [31:0] einst, logic [31:0] eipc, logic [31:0] ecnt);
    vec_t v;
    v.rq = rq; v.rv = rv; v.rd = rd; v.ir = ir; v.dv = dv; v.dpc = dpc;
    v.ereq = ereq; v.eaddr = eaddr; v.eiv = eiv; v.einst = einst; v.eipc = eipc;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic ereq, input logic [31:0] eaddr,
                         input logic eiv, input logic [31:0] einst, input logic [31:0] eipc,
                         input logic [31:0] ecnt);
    chk("req_valid", idx, {31'd0, imem_req_valid}, {31'd0, ereq});
    chk("req_addr", idx, imem_req_addr, eaddr);
    chk("inst_valid", idx, {31'd0, inst_valid}, {31'd0, eiv});
    chk("inst", idx, inst, einst);
    chk("inst_pc", idx, inst_pc, eipc);
    chk("fetch_count", idx, fetch_count, ecnt);
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // rq rv rd ir dv dpc | req addr iv inst ipc cnt
    vecs[0]  = mk(0, 0, 0,  0, 0, 0,            1, RPC,           0, NOP, RPC,           0);
    vecs[1]  = mk(0, 0, 0,  0, 0, 0,            1, RPC,           0, NOP, RPC,           0);
    vecs[2]  = mk(1, 0, 0,  0, 0, 0,            0, RPC,           0, NOP, RPC,           0);
    vecs[3]  = mk(0, 1, IA, 0, 0, 0,            0, RPC,           1, IA,  RPC,           0);
    vecs[4]  = mk(0, 0, 0,  1, 0, 0,            1, 32'h8000_0004, 0, IA,  RPC,           1);
    vecs[5]  = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0004, 0, IA,  RPC,           1);
    vecs[6]  = mk(0, 1, IB, 0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    // Five cycles of decode backpressure, one with a stray response.
    vecs[7]  = mk(0, 0, 0,  0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    vecs[8]  = mk(0, 0, 0,  0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    vecs[9]  = mk(1, 1, IC, 0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    vecs[10] = mk(0, 0, 0,  0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    vecs[11] = mk(0, 0, 0,  0, 0, 0,            0, 32'h8000_0004, 1, IB,  32'h8000_0004, 1);
    vecs[12] = mk(0, 0, 0,  1, 0, 0,            1, 32'h8000_0008, 0, IB,  32'h8000_0004, 2);
    vecs[13] = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0008, 0, IB,  32'h8000_0004, 2);
    // Redirect in WAIT before the response, then the stale response.
    vecs[14] = mk(0, 0, 0,  0, 1, 32'h8000_0100, 0, 32'h8000_0100, 0, IB, 32'h8000_0004, 2);
    vecs[15] = mk(0, 1, IC, 0, 0, 0,            1, 32'h8000_0100, 0, IB,  32'h8000_0004, 2);
    vecs[16] = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0100, 0, IB,  32'h8000_0004, 2);
    // Redirect together with the response; unaligned target.
    vecs[17] = mk(0, 1, IC, 0, 1, 32'h8000_0102, 1, 32'h8000_0100, 0, IB, 32'h8000_0004, 2);
    // Redirect together with the request handshake.
    vecs[18] = mk(1, 0, 0,  0, 1, 32'h8000_0102, 0, 32'h8000_0100, 0, IB, 32'h8000_0004, 2);
    vecs[19] = mk(0, 1, IC, 0, 0, 0,            1, 32'h8000_0100, 0, IB,  32'h8000_0004, 2);
    vecs[20] = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0100, 0, IB,  32'h8000_0004, 2);
    vecs[21] = mk(0, 1, IA, 0, 0, 0,            0, 32'h8000_0100, 1, IA,  32'h8000_0100, 2);
    // Redirect in HOLD with inst_ready=1: counted, pc takes the target.
    vecs[22] = mk(0, 0, 0,  1, 1, 32'h8000_0300, 1, 32'h8000_0300, 0, IA, 32'h8000_0100, 3);
    // Redirect in REQ without handshake changes the address.
    vecs[23] = mk(0, 0, 0,  0, 1, 32'h8000_0400, 1, 32'h8000_0400, 0, IA, 32'h8000_0100, 3);
    vecs[24] = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0400, 0, IA,  32'h8000_0100, 3);
    vecs[25] = mk(0, 1, IB, 0, 0, 0,            0, 32'h8000_0400, 1, IB,  32'h8000_0400, 3);
    // Redirect in HOLD with inst_ready=0: dropped, not counted.
    vecs[26] = mk(0, 0, 0,  0, 1, 32'h8000_0500, 1, 32'h8000_0500, 0, IB, 32'h8000_0400, 3);
    vecs[27] = mk(1, 0, 0,  0, 0, 0,            0, 32'h8000_0500, 0, IB,  32'h8000_0400, 3);
    // Two redirects while discarding: last one wins.
    vecs[28] = mk(0, 0, 0,  0, 1, 32'h8000_0600, 0, 32'h8000_0600, 0, IB, 32'h8000_0400, 3);
    vecs[29] = mk(0, 0, 0,  0, 1, 32'h8000_0703, 0, 32'h8000_0700, 0, IB, 32'h8000_0400, 3);
    vecs[30] = mk(0, 1, IC, 0, 0, 0,            1, 32'h8000_0700, 0, IB,  32'h8000_0400, 3);
    // PC wrap at the top of the address space.
    vecs[31] = mk(0, 0, 0,  0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, IB, 32'h8000_0400, 3);
    vecs[32] = mk(1, 0, 0,  0, 0, 0,            0, 32'hFFFF_FFFC, 0, IB,  32'h8000_0400, 3);
    vecs[33] = mk(0, 1, IA, 0, 0, 0,            0, 32'hFFFF_FFFC, 1, IA,  32'hFFFF_FFFC, 3);
    vecs[34] = mk(0, 0, 0,  1, 0, 0,            1, 32'h0000_0000, 0, IA,  32'hFFFF_FFFC, 4);
    vecs[35] = mk(1, 0, 0,  0, 0, 0,            0, 32'h0000_0000, 0, IA,  32'hFFFF_FFFC, 4);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_all(100, 1'b0, RPC, 1'b0, NOP, RPC, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      imem_req_ready  = vecs[i].rq;
      imem_resp_valid = vecs[i].rv;
      imem_resp_data  = vecs[i].rd;
      inst_ready      = vecs[i].ir;
      redirect_valid  = vecs[i].dv;
      redirect_pc     = vecs[i].dpc;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].ereq, vecs[i].eaddr, vecs[i].eiv, vecs[i].einst, vecs[i].eipc,
              vecs[i].ecnt);
    end

    // Asynchronous reset mid-cycle while a request is outstanding.
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(200, 1'b0, RPC, 1'b0, NOP, RPC, 32'd0);
    @(posedge clk);
    #1;
    chk_all(201, 1'b0, RPC, 1'b0, NOP, RPC, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (imem_req_valid) seen = 1'b1;
    end
    chk("restart_req_seen", 202, {31'd0, seen}, 32'd1);
    chk("restart_addr", 203, imem_req_addr, RPC);

    // Redirect while IDLE: stays IDLE one cycle, then requests the target.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0041;
    @(posedge clk);
    #1;
    chk("idle_redir_req", 204, {31'd0, imem_req_valid}, 32'd0);
    chk("idle_redir_addr", 204, imem_req_addr, 32'h8000_0040);
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_redir_req2", 205, {31'd0, imem_req_valid}, 32'd1);
    chk("idle_redir_addr2", 205, imem_req_addr, 32'h8000_0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
